// File: rtl/pc_unit.sv
// pc_unit: fetch program counter with redirect, trap, epoch tagging and misaligned-target fault
module pc_unit #(
  parameter int XLEN = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0,
  parameter int EPOCH_W = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               stall,
  output logic               fetch_valid,
  input  logic               fetch_ready,
  output logic [XLEN-1:0]    fetch_pc,
  output logic [EPOCH_W-1:0] fetch_epoch,
  input  logic               redir_valid,
  input  logic               redir_isjalr,
  input  logic [XLEN-1:0]    redir_base,
  input  logic [XLEN-1:0]    redir_offset,
  input  logic [XLEN-1:0]    redir_jalr_reg,
  input  logic               trap_valid,
  input  logic [XLEN-1:0]    trap_vector,
  output logic               fault,
  output logic [XLEN-1:0]    fault_pc,
  output logic [31:0]        fetch_cnt
);
  typedef enum logic [1:0] {S_BOOT, S_RUN, S_FAULT} state_t;
  state_t state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d, fault_pc_q, fault_pc_d, jalr_sum, target, trap_pc;
  logic [EPOCH_W-1:0] epoch_q, epoch_d;
  logic [31:0] cnt_q, cnt_d;
  logic hs;
  assign fetch_valid = (state_q == S_RUN) && !stall;
  assign fetch_pc    = pc_q;
  assign fetch_epoch = epoch_q;
  assign fault       = state_q == S_FAULT;
  assign fault_pc    = fault_pc_q;
  assign fetch_cnt   = cnt_q;
  // Trap beats redirect beats sequential increment; the counter tracks every accepted handshake regardless.
  always_comb begin
    hs         = fetch_valid && fetch_ready;
    jalr_sum   = redir_jalr_reg + redir_offset;
    target     = redir_isjalr ? {jalr_sum[XLEN-1:1], 1'b0} : redir_base + redir_offset;
    trap_pc    = {trap_vector[XLEN-1:2], 2'b00};
    state_d    = state_q;
    pc_d       = pc_q;
    epoch_d    = epoch_q;
    fault_pc_d = fault_pc_q;
    cnt_d      = cnt_q + 32'(hs);
    if (state_q == S_BOOT) begin
      state_d = S_RUN;
    end else if (trap_valid) begin
      pc_d    = trap_pc;
      epoch_d = epoch_q + EPOCH_W'(1);
      state_d = S_RUN;
    end else if (state_q == S_RUN && redir_valid) begin
      pc_d       = target[1:0] == 2'b00 ? target : pc_q;
      epoch_d    = target[1:0] == 2'b00 ? epoch_q + EPOCH_W'(1) : epoch_q;
      fault_pc_d = target[1:0] == 2'b00 ? fault_pc_q : target;
      state_d    = target[1:0] == 2'b00 ? S_RUN : S_FAULT;
    end else if (hs) begin
      pc_d = pc_q + XLEN'(4);
    end
  end
  // State register; reset abandons any in-flight request.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_BOOT;
      pc_q       <= RESET_VECTOR;
      epoch_q    <= '0;
      fault_pc_q <= '0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      epoch_q    <= epoch_d;
      fault_pc_q <= fault_pc_d;
      cnt_q      <= cnt_d;
    end
  end
endmodule

// File: tb/tb_pc_unit.sv
// tb_pc_unit: scoreboard bench for pc_unit driven by directed and random steps
module tb_pc_unit;
  logic clk = 0, rst = 0, stall = 0, fetch_ready = 0, redir_valid = 0, redir_isjalr = 0, trap_valid = 0;
  logic [31:0] redir_base = 0, redir_offset = 0, redir_jalr_reg = 0, trap_vector = 0;
  logic fetch_valid, fault;
  logic [31:0] fetch_pc, fault_pc, fetch_cnt;
  logic [1:0] fetch_epoch;
  int tests = 0, fails = 0;
  typedef struct {logic v; logic [31:0] pc; logic [1:0] ep; logic f; logic [31:0] fpc; logic [31:0] cnt;} exp_t;
  exp_t sb[$];
  int m_st = 0;
  logic [31:0] m_pc = 0, m_fpc = 0, m_cnt = 0;
  logic [1:0] m_ep = 0;
  pc_unit dut (
    .clk(clk), .rst(rst), .stall(stall), .fetch_valid(fetch_valid), .fetch_ready(fetch_ready),
    .fetch_pc(fetch_pc), .fetch_epoch(fetch_epoch), .redir_valid(redir_valid), .redir_isjalr(redir_isjalr),
    .redir_base(redir_base), .redir_offset(redir_offset), .redir_jalr_reg(redir_jalr_reg),
    .trap_valid(trap_valid), .trap_vector(trap_vector), .fault(fault), .fault_pc(fault_pc), .fetch_cnt(fetch_cnt)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic step(input logic st, input logic rdy, input logic rv, input logic rj, input logic [31:0] rb,
                      input logic [31:0] ro, input logic [31:0] rr, input logic tv, input logic [31:0] tvec, input logic r);
    logic hs;
    logic [31:0] tgt;
    exp_t e;
    @(negedge clk);
    stall = st; fetch_ready = rdy; redir_valid = rv; redir_isjalr = rj; redir_base = rb;
    redir_offset = ro; redir_jalr_reg = rr; trap_valid = tv; trap_vector = tvec; rst = r;
    hs = m_st == 1 && !st && rdy;
    tgt = rj ? ((rr + ro) & ~32'h1) : rb + ro;
    if (r) begin
      m_st = 0; m_pc = 0; m_ep = 0; m_fpc = 0; m_cnt = 0;
    end else begin
      if (hs) m_cnt = m_cnt + 1;
      if (m_st == 0) m_st = 1;
      else if (tv) begin
        m_pc = tvec & ~32'h3; m_ep = m_ep + 1; m_st = 1;
      end else if (m_st == 1 && rv) begin
        if (tgt[1:0] == 0) begin
          m_pc = tgt; m_ep = m_ep + 1;
        end else begin
          m_fpc = tgt; m_st = 2;
        end
      end else if (hs) m_pc = m_pc + 4;
    end
    e.v = m_st == 1 && !st; e.pc = m_pc; e.ep = m_ep; e.f = m_st == 2; e.fpc = m_fpc; e.cnt = m_cnt;
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk("fetch_valid", 32'(fetch_valid), 32'(e.v));
    chk("fetch_pc", fetch_pc, e.pc);
    chk("fetch_epoch", 32'(fetch_epoch), 32'(e.ep));
    chk("fault", 32'(fault), 32'(e.f));
    chk("fault_pc", fault_pc, e.fpc);
    chk("fetch_cnt", fetch_cnt, e.cnt);
  endtask
  initial begin
    step(0, 1, 0, 0, 0, 0, 0, 0, 0, 1);
    step(0, 1, 0, 0, 0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 3; i++) step(0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 1, 1, 0, 32'h100, 32'hFFFFFFF0, 0, 0, 0, 0);
    step(0, 1, 1, 1, 0, 32'h2, 32'h2001, 0, 0, 0);
    step(0, 1, 1, 0, 32'h400, 32'h0, 0, 0, 0, 0);
    step(0, 1, 1, 0, 32'h400, 32'h0, 0, 1, 32'h80000005, 0);
    step(0, 1, 1, 0, 32'h200, 32'h4, 0, 0, 0, 0);
    step(0, 1, 1, 1, 0, 32'h10, 32'h301, 0, 0, 0);
    step(1, 1, 1, 0, 32'h500, 32'h8, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0, 1, 32'h00001236, 0);
    step(0, 1, 1, 0, 32'h100, 32'h1, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0, 0, 0, 1, 32'h40, 1);
    step(0, 1, 1, 0, 32'h800, 0, 0, 1, 32'h40, 0);
    step(0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 80; i++)
      step($urandom_range(0, 3) == 0, $urandom_range(0, 3) != 0, $urandom_range(0, 4) == 0, 1'($urandom),
           $urandom, $urandom_range(0, 1) ? 32'($urandom_range(0, 15)) << 2 : $urandom, $urandom,
           $urandom_range(0, 9) == 0, $urandom, $urandom_range(0, 29) == 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
